// File: rtl/acc_buf_pkg.sv
// Shared defaults and drain FSM state type for the double-banked accumulation buffer.
package acc_buf_pkg;

    localparam int unsigned ACC_DATA_WIDTH      = 64;
    localparam int unsigned ACC_BANK_ADDR_WIDTH = 7;
    localparam int unsigned ACC_BANK_DEPTH      = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_e;

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry registered skid FIFO; the head register directly drives the output word.
module wb_skid_fifo #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            occupancy,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_valid
);

    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic [1:0]            occ_q;

    // Head/tail shift storage; head only changes on a pop or a push into an empty FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            case (occ_q)
                2'd0: begin
                    if (push) begin
                        head_q <= push_data;
                        occ_q  <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({push, pop})
                        2'b10: begin
                            tail_q <= push_data;
                            occ_q  <= 2'd2;
                        end
                        2'b01: occ_q <= 2'd0;
                        2'b11: head_q <= push_data;
                        default: ;
                    endcase
                end
                2'd2: begin
                    if (pop) begin
                        head_q <= tail_q;
                        if (push) begin
                            tail_q <= push_data;
                        end else begin
                            occ_q <= 2'd1;
                        end
                    end
                end
                default: occ_q <= 2'd0;
            endcase
        end
    end

    assign occupancy  = occ_q;
    assign head_data  = head_q;
    assign head_valid = (occ_q != 2'd0);

endmodule

// File: rtl/accumulation_writeback_drain.sv
// Drains the writeback bank onto a valid/ready stream, absorbing the 1-cycle read latency.
module accumulation_writeback_drain
    import acc_buf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = ACC_DATA_WIDTH,
    parameter int unsigned BANK_ADDR_WIDTH = ACC_BANK_ADDR_WIDTH,
    parameter int unsigned BANK_DEPTH      = ACC_BANK_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BANK_ADDR_WIDTH:0]   count,
    output logic                       busy,
    output logic                       done,
    output logic                       ren_wb,
    output logic [BANK_ADDR_WIDTH-1:0] radr_wb,
    input  logic [DATA_WIDTH-1:0]      rdata_wb,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data
);

    localparam int unsigned CW = BANK_ADDR_WIDTH + 1;

    drain_state_e         state_q, state_d;
    logic [CW-1:0]        rem_rd_q;
    logic [CW-1:0]        rem_out_q;
    logic [CW-1:0]        clamped;
    logic [BANK_ADDR_WIDTH-1:0] addr_q;
    logic                 inflight_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 ren_c;
    logic                 pop;
    logic [1:0]           occupancy;
    logic [2:0]           level;

    assign clamped = (count > CW'(BANK_DEPTH)) ? CW'(BANK_DEPTH) : count;
    assign pop     = out_valid & out_ready;
    // Slots that will be committed next cycle; a new read is safe only if one stays free.
    assign level   = 3'(occupancy) + 3'(inflight_q) - 3'(pop);

    // Next-state and read-issue decode.
    always_comb begin
        state_d = state_q;
        ren_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (clamped == '0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((rem_rd_q != '0) && (level < 3'd2)) begin
                    ren_c = 1'b1;
                    if (rem_rd_q == CW'(1)) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (pop && (rem_out_q == CW'(1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters, inflight flag and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rem_rd_q   <= '0;
            rem_out_q  <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= ren_c;
            busy_q     <= (state_d == ST_DRAIN) || (state_d == ST_FLUSH);
            done_q     <= (state_d == ST_DONE);
            if ((state_q == ST_IDLE) && start) begin
                rem_rd_q  <= clamped;
                rem_out_q <= clamped;
                addr_q    <= '0;
            end else begin
                if (ren_c) begin
                    rem_rd_q <= rem_rd_q - CW'(1);
                    addr_q   <= addr_q + BANK_ADDR_WIDTH'(1);
                end
                if (pop && (rem_out_q != '0)) begin
                    rem_out_q <= rem_out_q - CW'(1);
                end
            end
        end
    end

    wb_skid_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_q),
        .push_data  (rdata_wb),
        .pop        (pop),
        .occupancy  (occupancy),
        .head_data  (out_data),
        .head_valid (out_valid)
    );

    assign ren_wb  = ren_c;
    assign radr_wb = addr_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_accumulation_writeback_drain.sv
// Directed scoreboard bench for the writeback drain.
module tb_accumulation_writeback_drain;
    import acc_buf_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  count;
    logic        busy, done, ren_wb;
    logic [6:0]  radr_wb;
    logic [63:0] rdata_wb = '0;
    logic        out_valid, out_ready;
    logic [63:0] out_data;

    accumulation_writeback_drain dut (
        .clk(clk), .rst(rst), .start(start), .count(count),
        .busy(busy), .done(done), .ren_wb(ren_wb), .radr_wb(radr_wb),
        .rdata_wb(rdata_wb), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    logic [63:0] bank [128];
    logic [63:0] exp_q [$];
    int checks = 0, errors = 0;
    int cyc = 0, c0 = 0;
    int pops, ren_cnt, done_cnt, done_cyc, first_ren, first_pop, last_pop, busy_seen, exp_addr;
    int tb_occ = 0;
    bit prev_ren = 0, prev_stall = 0, bp = 0;
    logic [63:0] prev_data = '0;
    int phase = 0;
    int pat [4] = '{1, 0, 0, 1};

    // Bank model with fixed 1-cycle read latency.
    always @(posedge clk) if (ren_wb) rdata_wb <= bank[radr_wb];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stream monitor: scoreboard pops, address walk, issue rule, stall stability.
    always @(negedge clk) begin
        int  infl;
        int  p;
        int  rel;
        if (rst) begin
            tb_occ = 0; prev_ren = 0; prev_stall = 0;
        end else begin
            rel  = cyc - c0 + 1;
            infl = prev_ren ? 1 : 0;
            p    = (out_valid && out_ready) ? 1 : 0;
            check("valid_vs_model", 64'(out_valid), 64'(tb_occ != 0));
            if (ren_wb) begin
                check("ren_rule", 64'((tb_occ + infl - p) < 2), 64'd1);
                check("radr_wb", 64'(radr_wb), 64'(exp_addr[6:0]));
                if (ren_cnt == 0) first_ren = rel;
                ren_cnt++;
                exp_addr++;
            end
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", out_data, prev_data);
            end
            if (p == 1) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $error("FAIL unexpected_pop: observed %0h expected none", out_data);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
                if (pops == 0) first_pop = rel;
                last_pop = rel;
                pops++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = rel;
                check("busy_at_done", 64'(busy), 64'd0);
            end
            if (busy) busy_seen++;
            tb_occ     = tb_occ + infl - p;
            prev_ren   = ren_wb;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (bp) begin
            out_ready = pat[phase % 4] != 0;
            phase++;
        end else begin
            out_ready = 1'b1;
        end
    endtask

    task automatic clear_mon();
        pops = 0; ren_cnt = 0; done_cnt = 0; done_cyc = -1; first_ren = -1;
        first_pop = -1; last_pop = -1; busy_seen = 0; exp_addr = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_ren"}, 64'(ren_wb), 64'd0);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_radr"}, 64'(radr_wb), 64'd0);
        check({tag, "_data"}, out_data, 64'd0);
    endtask

    task automatic run(input string tag, input int cnt, input int words, input bit use_bp,
                       input int budget, input int ignore_at);
        clear_mon();
        exp_q.delete();
        for (int w = 0; w < words; w++) exp_q.push_back(bank[w]);
        bp = use_bp; phase = 0;
        start = 1'b1; count = 8'(cnt);
        step();
        start = 1'b0;
        c0 = cyc;
        if (cnt > 0) check({tag, "_busy_c1"}, 64'(busy), 64'd1);
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            if (i == ignore_at) begin start = 1'b1; count = 8'd4; end
            else start = 1'b0;
            step();
        end
        start = 1'b0;
        check({tag, "_no_timeout"}, 64'(done_cnt > 0), 64'd1);
        step(); step();
        bp = 0;
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_pops"}, 64'(pops), 64'(words));
        check({tag, "_reads"}, 64'(ren_cnt), 64'(words));
        check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; count = '0; out_ready = 1'b1;
        clear_mon();
        for (int i = 0; i < 128; i++) bank[i] = 64'(i) * 64'h10;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        step();

        run("full", 16, 16, 0, 100, -1);
        check("full_first_ren", 64'(first_ren), 64'd1);
        check("full_first_pop", 64'(first_pop), 64'd3);
        check("full_last_pop", 64'(last_pop), 64'd18);
        check("full_done_cyc", 64'(done_cyc), 64'd19);

        run("bp", 16, 16, 1, 200, -1);

        run("zero", 0, 0, 0, 20, -1);
        check("zero_done_cyc", 64'(done_cyc), 64'd1);
        check("zero_busy_seen", 64'(busy_seen), 64'd0);

        for (int i = 0; i < 128; i++) bank[i] = 64'hA500_0000 + 64'(i);
        run("clamp", 200, 128, 0, 300, -1);
        check("clamp_addr_walk", 64'(exp_addr), 64'd128);

        run("ignored_start", 8, 8, 0, 60, 3);

        // Reset in the middle of an 8-word drain.
        clear_mon();
        exp_q.delete();
        for (int w = 0; w < 8; w++) exp_q.push_back(bank[w]);
        start = 1'b1; count = 8'd8;
        step();
        start = 1'b0;
        c0 = cyc;
        for (int i = 0; i < 50 && pops < 5; i++) step();
        check("rst_mid_pops", 64'(pops), 64'd5);
        rst = 1'b1;
        #1;
        check_outputs_zero("rst_mid");
        step(); step();
        rst = 1'b0;
        check("rst_mid_no_done", 64'(done_cnt), 64'd0);
        step();
        check("rst_mid_no_done_after", 64'(done_cnt), 64'd0);
        run("after_reset", 3, 3, 0, 50, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
